seq_shift_add_mult: RTL and testbench

- Sequential unsigned N×N shift-and-add multiplier for the datapath multiplier.
- Operands are captured on a start pulse and one partial product is accumulated per clock.
- Completion is flagged when the iteration counter is no longer not-equal to N, using the team's existing inequality comparator as the loop-exit test.
- Sits between the operand registers and the result register; a control FSM handshakes with the upstream sequencer.

---
 rtl/seq_shift_add_mult.sv | 116 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned N x N shift-and-add multiplier. Each RUN cycle adds one partial product.
// The loop ends after exactly N iterations, and the 2N-bit product is held until the next result.
module seq_shift_add_mult #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   product_q, product_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    cnt_inc;
  logic [2*N-1:0]   acc_sum;
  logic             cnt_ne_last;

  // Shared inequality comparator; the loop exits once it stops reporting "not equal".
  function automatic logic ne_cmp(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return x != y;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;

    cnt_inc     = cnt_q + CNT_ONE;
    acc_sum     = mplier_q[0] ? acc_q + mcand_q : acc_q;
    cnt_ne_last = ne_cmp(cnt_inc, CNT_LAST);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_inc;
        if (!cnt_ne_last) begin
          state_d   = DONE;
          product_d = acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: an N=4 and an N=8 instance share the stimulus,
// and sel8 chooses which instance is driven and observed.
module tb_seq_shift_add_mult;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sel8;
  logic [7:0]  a_in;
  logic [7:0]  b_in;

  logic        start4, busy4, done4;
  logic [7:0]  product4;
  logic        start8, busy8, done8;
  logic [15:0] product8;

  logic        busy_m, done_m;
  logic [15:0] product_m;

  int n_tests = 0;
  int n_fail  = 0;

  assign start4    = start & ~sel8;
  assign start8    = start & sel8;
  assign busy_m    = sel8 ? busy8 : busy4;
  assign done_m    = sel8 ? done8 : done4;
  assign product_m = sel8 ? product8 : {8'h00, product4};

  seq_shift_add_mult #(.N(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .a       (a_in[3:0]),
    .b       (b_in[3:0]),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  seq_shift_add_mult #(.N(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Starts one operation and follows it to completion, checking latency, result and hold.
  task automatic run_op(input logic w8, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input string tag);
    int busy_n;
    int guard;
    logic [15:0] held;
    sel8  = w8;
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    busy_n = 0;
    guard  = 0;
    while (!done_m && guard < 40) begin
      if (busy_m) busy_n++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, 32'(done_m), 32'd1);
    check({tag, "_busy_excl"}, 32'(busy_m), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_n), w8 ? 32'd8 : 32'd4);
    check({tag, "_product"}, 32'(product_m), 32'(exp));
    held = product_m;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
    check({tag, "_hold"}, 32'(product_m), 32'(exp));
  endtask

  initial begin
    int guard;
    int cyc;
    int pulses;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    sel8  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_product", 32'(product_m), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 8'd13, 8'd11, 16'd143, "basic");

    // Asynchronous reset two RUN cycles into an operation.
    a_in  = 8'd9;
    b_in  = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midop_busy_before", 32'(busy_m), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midop_busy", 32'(busy_m), 32'd0);
    check("midop_done", 32'(done_m), 32'd0);
    check("midop_product", 32'(product_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_m || busy_m) pulses++;
    end
    check("midop_after_release", 32'(pulses), 32'd0);

    run_op(1'b0, 8'd15, 8'd15, 16'd225, "c_15x15");
    run_op(1'b0, 8'd0,  8'd15, 16'd0,   "c_0x15");
    run_op(1'b0, 8'd15, 8'd0,  16'd0,   "c_15x0");
    run_op(1'b0, 8'd1,  8'd1,  16'd1,   "c_1x1");

    // A start pulse during RUN must be ignored.
    sel8  = 1'b0;
    a_in  = 8'd3;
    b_in  = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in  = 8'd12;
    b_in  = 8'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_m) pulses++;
      @(negedge clk);
    end
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_product", 32'(product_m), 32'd15);

    // Back-to-back: start held high, new operands presented during DONE.
    a_in  = 8'd6;
    b_in  = 8'd7;
    start = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!done_m && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_first_done", 32'(done_m), 32'd1);
    check("b2b_first_product", 32'(product_m), 32'd42);
    a_in = 8'd10;
    b_in = 8'd9;
    @(negedge clk);
    start = 1'b0;
    check("b2b_rerun_busy", 32'(busy_m), 32'd1);
    cyc   = 1;
    guard = 0;
    while (!done_m && guard < 20) begin
      check("b2b_hold_42", 32'(product_m), 32'd42);
      @(negedge clk);
      cyc++;
      guard++;
    end
    check("b2b_second_done", 32'(done_m), 32'd1);
    check("b2b_spacing", 32'(cyc), 32'd5);
    check("b2b_second_product", 32'(product_m), 32'd90);
    @(negedge clk);

    run_op(1'b1, 8'd255, 8'd255, 16'd65025, "w8_max");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(1'b1, ra, rb, 16'(ra) * 16'(rb), "sweep");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
